// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter: 8N1 frames, LSB first, divider-based bit timing.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1, sense set by PARITY_ODD).
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       dataReady,
    output logic       busy,
    output logic       tx
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             stopCnt_q, stopCnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             lastTick;

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;
`else
    logic unusedParityOdd;
    assign unusedParityOdd = PARITY_ODD;
`endif

    assign lastTick = (divCnt_q == DIV_LAST);
    assign tx       = tx_q;
    assign busy     = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            stopCnt_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            stopCnt_q <= stopCnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // tx_d is the value of the line for the next cycle, so every bit boundary
    // loads the upcoming bit one edge early and tx stays a pure flop output.
    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        stopCnt_d = stopCnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                divCnt_d  = '0;
                bitIdx_d  = '0;
                stopCnt_d = 1'b0;
                if (dataReady) begin
                    shift_d = data;
                    state_d = START;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^data) ^ PARITY_ODD;
`endif
                end
            end

            START: begin
                if (lastTick) begin
                    divCnt_d = '0;
                    bitIdx_d = '0;
                    state_d  = DATA;
                    tx_d     = shift_q[0];
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end

            DATA: begin
                if (lastTick) begin
                    divCnt_d = '0;
                    shift_d  = shift_q >> 1;
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d   = STOP;
                        stopCnt_d = 1'b0;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (lastTick) begin
                    divCnt_d  = '0;
                    stopCnt_d = 1'b0;
                    state_d   = STOP;
                    tx_d      = 1'b1;
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end
`endif

            STOP: begin
                tx_d = 1'b1;
                if (lastTick) begin
                    divCnt_d = '0;
                    if (stopCnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        stopCnt_d = stopCnt_q + 1'b1;
                    end
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                divCnt_d  = '0;
                bitIdx_d  = '0;
                stopCnt_d = 1'b0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: table-driven frames on two configurations
// (1 stop bit/even parity and 2 stop bits/odd parity) plus reset and back-to-back sequences.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_SLOTS = 1;
`else
    localparam int PAR_SLOTS = 0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] dataIn;
    logic       readyA, readyB;
    logic       busyA, busyB;
    logic       txA, txB;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] slots;
        logic       evenPar;
        bit         changeData;
    } vec_t;

    vec_t vecs[5];

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1'b0)) dutA (
        .clk(clk), .reset(reset), .data(dataIn), .dataReady(readyA), .busy(busyA), .tx(txA)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1'b1)) dutB (
        .clk(clk), .reset(reset), .data(dataIn), .dataReady(readyB), .busy(busyB), .tx(txB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic getTx(input int sel);
        return (sel == 0) ? txA : txB;
    endfunction

    function automatic logic getBusy(input int sel);
        return (sel == 0) ? busyA : busyB;
    endfunction

    // Slot 0 is the start bit, 1..8 data, then optional parity, then stop bits.
    function automatic logic expSlot(input vec_t v, input int slot, input bit parOdd);
        if (slot < 9) return v.slots[slot];
        if (PAR_SLOTS == 1 && slot == 9) return v.evenPar ^ parOdd;
        return 1'b1;
    endfunction

    task automatic setReady(input int sel, input logic val);
        if (sel == 0) readyA = val;
        else          readyB = val;
    endtask

    task automatic applyStimulus(input int sel, input vec_t v, input int stopBits, input bit parOdd, input string tag);
        int nSlots;
        int busyCnt;
        nSlots  = 9 + PAR_SLOTS + stopBits;
        busyCnt = 0;
        @(negedge clk);
        checkOutput($sformatf("%s busy before accept", tag), getBusy(sel), 0);
        dataIn = v.data;
        setReady(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        setReady(sel, 1'b0);
        for (int s = 0; s < nSlots; s++) begin
            for (int k = 0; k < CPB; k++) begin
                if (v.changeData && s == 0 && k == 2) dataIn = 8'hFF;
                checkOutput($sformatf("%s slot%0d cyc%0d tx", tag, s, k), getTx(sel), expSlot(v, s, parOdd));
                if (getBusy(sel) === 1'b1) busyCnt++;
                @(negedge clk);
            end
        end
        checkOutput($sformatf("%s busy length", tag), busyCnt, nSlots * CPB);
        checkOutput($sformatf("%s busy low after frame", tag), getBusy(sel), 0);
        checkOutput($sformatf("%s tx idle after frame", tag), getTx(sel), 1);
    endtask

    initial begin
        vec_t v00;
        vec_t v51;
        int n;
        int lo;
        int onesRun;
        logic gapTx;

        vecs[0] = '{8'h51, 10'b1010100010, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 10'b1101001010, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 10'b1000000000, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 10'b1111111110, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 10'b1100000000, 1'b1, 1'b0};
        v51 = vecs[0];
        v00 = vecs[2];

        reset  = 1'b1;
        readyA = 1'b0;
        readyB = 1'b0;
        dataIn = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset txA", txA, 1);
        checkOutput("reset busyA", busyA, 0);
        checkOutput("reset txB", txB, 1);
        checkOutput("reset busyB", busyB, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++)
            applyStimulus(0, vecs[i], 1, 1'b0, $sformatf("A vec%0d", i));

        applyStimulus(1, v00, 2, 1'b1, "B 00");
        applyStimulus(1, v51, 2, 1'b1, "B 51");

        // Back-to-back frames with dataReady held high on the 1-stop-bit unit.
        @(negedge clk);
        dataIn = 8'h00;
        readyA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        onesRun = 0;
        while (busyA === 1'b1 && n < 200) begin
            if (txA === 1'b1) onesRun++;
            else              onesRun = 0;
            n++;
            @(negedge clk);
        end
        checkOutput("b2b first busy length", n, (10 + PAR_SLOTS) * CPB);
        lo = 0;
        gapTx = txA;
        while (busyA !== 1'b1 && lo < 10) begin
            if (txA === 1'b1) onesRun++;
            lo++;
            @(negedge clk);
        end
        checkOutput("b2b busy gap", lo, 1);
        checkOutput("b2b gap tx", gapTx, 1);
        checkOutput("b2b tx high run", onesRun, CPB + 1);
        checkOutput("b2b second start tx", txA, 0);
        checkOutput("b2b second busy", busyA, 1);
        readyA = 1'b0;
        n = 0;
        while (busyA === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("b2b second frame ends", busyA, 0);
        checkOutput("b2b second busy length", n, (10 + PAR_SLOTS) * CPB);

        // Reset asserted during the third data bit (slot 3, tx low for 8'h51).
        @(negedge clk);
        dataIn = 8'h51;
        readyA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        readyA = 1'b0;
        repeat (13) @(negedge clk);
        checkOutput("midframe busy before reset", busyA, 1);
        checkOutput("midframe tx before reset", txA, 0);
        reset = 1'b1;
        #1;
        checkOutput("midframe reset tx", txA, 1);
        checkOutput("midframe reset busy", busyA, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post reset tx cyc%0d", i), txA, 1);
            checkOutput($sformatf("post reset busy cyc%0d", i), busyA, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
